// File: rtl/axi_io_pkg.sv
// Shared constants, FSM encoding and burst sizing helper for the AXI write-side controller.
package axi_io_pkg;

  localparam int BYTES       = 64;
  localparam int BOUNDARY_4K = 4096;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} wr_state_e;

  // Beats in the next burst: limited by what is left, the burst cap and the 4 KB page room.
  function automatic logic [8:0] burst_beats(input logic [26:0] rem,
                                             input logic [12:0] room,
                                             input logic [8:0]  max_burst);
    logic [26:0] n;
    n = rem;
    if (n > {18'd0, max_burst}) n = {18'd0, max_burst};
    if (n > {14'd0, room})      n = {14'd0, room};
    return n[8:0];
  endfunction

endpackage

// File: rtl/burst_len_fifo.sv
// Small synchronous FIFO holding the beat count of each issued burst until its data has gone out.
module burst_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp, rp;
  logic [PW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= (wp == PW'(DEPTH-1)) ? '0 : wp + PW'(1);
      if (do_pop)  rp <= (rp == PW'(DEPTH-1)) ? '0 : rp + PW'(1);
      if (do_push && !do_pop)      cnt <= cnt + (PW+1)'(1);
      else if (!do_push && do_pop) cnt <= cnt - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/axi_wr_burst_ctrl.sv
// Splits one output stream into AXI write bursts: 4 KB-safe, length-capped, bounded in-flight
// count, with the job's final beat strobe trimmed to the byte length.
module axi_wr_burst_ctrl
  import axi_io_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   des_addr,
  input  logic [31:0]             length,
  output logic                    idle,
  output logic                    done,
  output logic                    ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [DATA_WIDTH/8-1:0] s_strb,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    wr_req,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [7:0]              wr_len,
  input  logic                    wr_req_ack,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    wr_wvalid,
  output logic                    wr_last,
  input  logic                    wr_ready,
  output logic                    bready,
  input  logic                    bresp_valid
);
  localparam int BB  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BB);
  localparam int TW  = (BB > 1) ? $clog2(BB) : 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  wr_state_e             state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [26:0]           rem_q, left_q, total;
  logic [TW-1:0]         tail_q;
  logic [OW-1:0]         outs_q, outs_nxt;
  logic [8:0]            bcnt_q, n, head;
  logic [12:0]           room;
  logic [32:0]           len_rnd;
  logic [BB-1:0]         mask;
  logic                  fifo_empty, fifo_full, have, ack, hs, pop, resp, take;

  assign len_rnd = {1'b0, length} + 33'(BB - 1);
  assign total   = 27'(len_rnd >> OFF);
  assign take    = (state == ST_IDLE) & start;

  // Address side
  assign room    = (13'(BOUNDARY_4K) - {1'b0, addr_q[11:0]}) >> OFF;
  assign n       = burst_beats(rem_q, room, 9'(MAX_BURST));
  assign wr_req  = (state == ST_RUN) && (rem_q != '0) &&
                   (outs_q != OW'(MAX_OUTSTANDING)) && !fifo_full;
  assign wr_addr = addr_q;
  assign wr_len  = wr_req ? 8'(n - 9'd1) : 8'd0;
  assign ack     = wr_req & wr_req_ack;

  // Data side: combinational pass-through gated by an issued-but-unsent burst
  assign have      = ~fifo_empty;
  assign s_ready   = wr_ready & have;
  assign wr_wvalid = s_valid & have;
  assign wr_data   = s_data;
  assign hs        = s_valid & s_ready;
  assign wr_last   = have & (bcnt_q == head - 9'd1);
  assign pop       = hs & wr_last;

  for (genvar i = 0; i < BB; i++) begin : g_mask
    assign mask[i] = (i < int'(tail_q));
  end
  assign wr_strb = ((left_q == 27'd1) && (tail_q != '0)) ? (s_strb & mask) : s_strb;

  assign bready = rst_n;
  assign resp   = bresp_valid & bready & (outs_q != '0);
  assign idle   = (state == ST_IDLE);
  assign done   = (state == ST_DONE);
  assign ready  = done;

  always_comb begin
    outs_nxt = outs_q;
    if (ack && !resp)      outs_nxt = outs_q + OW'(1);
    else if (!ack && resp) outs_nxt = outs_q - OW'(1);
  end

  // Looking at outs_nxt lets done follow the final response by exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (length == 32'd0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (rem_q == '0 && left_q == '0)
                  state_nxt = (outs_nxt == '0) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (outs_nxt == '0) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      rem_q  <= '0;
      left_q <= '0;
      tail_q <= '0;
      outs_q <= '0;
      bcnt_q <= '0;
    end else begin
      state  <= state_nxt;
      outs_q <= outs_nxt;
      if (take) begin
        addr_q <= des_addr & ~ADDR_WIDTH'(BB - 1);
        rem_q  <= total;
        left_q <= total;
        tail_q <= (BB > 1) ? length[TW-1:0] : '0;
        bcnt_q <= '0;
      end else begin
        if (ack) begin
          addr_q <= addr_q + (ADDR_WIDTH'(n) << OFF);
          rem_q  <= rem_q - 27'(n);
        end
        if (hs) begin
          left_q <= left_q - 27'd1;
          bcnt_q <= wr_last ? 9'd0 : bcnt_q + 9'd1;
        end
      end
    end
  end

  burst_len_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(9)) u_len_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ack),
    .din   (n),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_axi_wr_burst_ctrl.sv
// Directed jobs with randomized handshakes, checked against a burst-list reference model.
module tb_axi_wr_burst_ctrl;
  localparam int DW = 512, AW = 64, MB = 64, MO = 2, BB = DW / 8;

  logic          clk = 0, rst_n = 1, start = 0;
  logic [AW-1:0] des_addr = '0;
  logic [31:0]   length = '0;
  logic          idle, done, ready, s_ready, wr_req, wr_wvalid, wr_last, bready;
  logic [DW-1:0] s_data = '0, wr_data;
  logic [BB-1:0] s_strb = '0, wr_strb;
  logic          s_valid = 0, wr_req_ack = 0, wr_ready = 0, bresp_valid = 0;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_len;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  axi_wr_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .des_addr(des_addr), .length(length),
    .idle(idle), .done(done), .ready(ready), .s_data(s_data), .s_strb(s_strb),
    .s_valid(s_valid), .s_ready(s_ready), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_len(wr_len), .wr_req_ack(wr_req_ack), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_wvalid(wr_wvalid), .wr_last(wr_last), .wr_ready(wr_ready), .bready(bready),
    .bresp_valid(bresp_valid)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic idle_inputs();
    wr_req_ack = 0; wr_ready = 0; s_valid = 0; bresp_valid = 0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_idle"}, idle, 1);       chk({tag, "_done"}, done, 0);
    chk({tag, "_ready"}, ready, 0);     chk({tag, "_wr_req"}, wr_req, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0); chk({tag, "_wr_len"}, wr_len, 0);
    chk({tag, "_wvalid"}, wr_wvalid, 0); chk({tag, "_wr_last"}, wr_last, 0);
    chk({tag, "_s_ready"}, s_ready, 0); chk({tag, "_bready"}, bready, 0);
  endtask

  // Runs one job; the model is the list of expected bursts plus simple beat/response counts.
  task automatic run_job(input logic [63:0] a, input int unsigned len, input bit hold);
    logic [63:0] ea[$];
    int          en[$];
    logic [63:0] aa, smask;
    int          rem, room, n, total, tail, acked, cmpl, sent, bib, nresp, fin;
    bit          ok, go, fire;
    aa = a & ~64'(BB - 1);
    total = int'((64'(len) + 64'(BB - 1)) / 64'(BB));
    rem = total;
    while (rem > 0) begin
      room = int'((64'd4096 - (aa % 64'd4096)) / 64'(BB));
      n = rem;
      if (n > MB) n = MB;
      if (n > room) n = room;
      ea.push_back(aa); en.push_back(n);
      aa += 64'(n * BB); rem -= n;
    end
    tail  = int'(len % BB);
    smask = (tail == 0) ? '1 : ((64'd1 << tail) - 64'd1);

    @(posedge clk); #1;
    start = 1; des_addr = a; length = len;
    @(posedge clk); #1;
    start = 0; des_addr = {$urandom, $urandom}; length = $urandom;
    if (len == 0) begin
      @(negedge clk);
      chk("zero_done", done, 1); chk("zero_ready", ready, 1); chk("zero_no_req", wr_req, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("zero_done_drop", done, 0); chk("zero_idle", idle, 1);
      return;
    end

    acked = 0; cmpl = 0; sent = 0; bib = 0; nresp = 0; fin = -1; ok = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      wr_req_ack  = ($urandom % 4) != 0;
      wr_ready    = ($urandom % 4) != 0;
      s_valid     = ($urandom % 4) != 0;
      s_data      = rnd_data();
      s_strb      = {$urandom, $urandom};
      bresp_valid = (cmpl > nresp) && !(hold && cyc < 300) && (($urandom % 3) == 0);
      @(negedge clk);
      chk("done", done, (fin >= 0) && (cyc == fin + 1));
      chk("ready", ready, (fin >= 0) && (cyc == fin + 1));
      chk("idle", idle, (fin >= 0) && (cyc == fin + 2));
      if (fin >= 0 && cyc == fin + 2) begin ok = 1; break; end
      if (cyc == 0) chk("bready_run", bready, 1);
      go = (acked < en.size()) && (acked - nresp < MO);
      chk("wr_req", wr_req, go);
      if (go) begin
        chk("wr_addr", wr_addr, ea[acked]);
        chk("wr_len", wr_len, en[acked] - 1);
        chk("no_4k_cross", ({52'd0, wr_addr[11:0]} + (64'(wr_len) + 64'd1) * 64'(BB)) <= 64'd4096, 1);
      end
      if (hold && cyc == 299) chk("third_req_held", wr_req, 0);
      fire = s_valid && wr_ready && (cmpl < acked);
      chk("s_ready", s_ready, wr_ready && (cmpl < acked));
      chk("wr_wvalid", wr_wvalid, s_valid && (cmpl < acked));
      if (fire) begin
        chk("wr_data", wr_data, s_data);
        chk("wr_strb", wr_strb, (sent == total - 1) ? (s_strb & smask) : s_strb);
        chk("wr_last", wr_last, bib == en[cmpl] - 1);
        sent++;
        if (bib == en[cmpl] - 1) begin bib = 0; cmpl++; end
        else bib++;
      end
      if (go && wr_req_ack) acked++;
      if (bresp_valid) begin
        nresp++;
        if (nresp == en.size()) fin = cyc;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    tests++;
    assert (ok) else begin
      fails++;
      $error("FAIL job_timeout: job at %0h len %0d did not complete, got %0d beats expected %0d", a, len, sent, total);
    end
  endtask

  initial begin
    // reset with the stream side pushing, so gating of s_ready/wr_wvalid is exercised
    s_valid = 1; wr_ready = 1;
    #1 rst_n = 0;
    #1 reset_checks("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    idle_inputs();
    @(negedge clk);
    chk("bready_after_reset", bready, 1);

    run_job(64'h1000, 8192, 0);
    run_job(64'h1F80, 256, 0);
    run_job(64'h0, 100, 0);
    run_job(64'h0, 5 * 4096, 1);
    run_job(64'h3000, 0, 0);
    run_job(64'h0FC5, 130, 0);

    // reset in the middle of a burst, then a clean job
    @(posedge clk); #1;
    start = 1; des_addr = 64'h1000; length = 8192;
    @(posedge clk); #1;
    start = 0; wr_req_ack = 1; wr_ready = 1; s_valid = 1; s_data = rnd_data(); s_strb = '1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("midjob_wvalid", wr_wvalid, 1);
    #2 rst_n = 0;
    #1 reset_checks("midjob_reset");
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1;
    run_job(64'h2040, 3000, 0);

    for (int k = 0; k < 5; k++)
      run_job({32'd0, $urandom}, $urandom_range(1, 16000), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
